// File: rtl/alu_pkg.sv
// Shared operation codes for the 32-bit ALU: sel[3:2] groups and sel[1:0] sub-codes.
package alu_pkg;

   localparam logic [1:0] OP_ARITH = 2'b00;
   localparam logic [1:0] OP_LOGIC = 2'b01;
   localparam logic [1:0] OP_SHR   = 2'b10;
   localparam logic [1:0] OP_SHL   = 2'b11;

   localparam logic [1:0] LOGIC_AND = 2'b00;
   localparam logic [1:0] LOGIC_OR  = 2'b01;
   localparam logic [1:0] LOGIC_XOR = 2'b10;
   localparam logic [1:0] LOGIC_NOT = 2'b11;

   localparam logic [1:0] ARITH_Y_ZERO = 2'b00;
   localparam logic [1:0] ARITH_Y_B    = 2'b01;
   localparam logic [1:0] ARITH_Y_NB   = 2'b10;
   localparam logic [1:0] ARITH_Y_ONES = 2'b11;

endpackage

// File: rtl/alu_arith_unit.sv
// Arithmetic half of the ALU: selects the second operand Y and forms {cout, sum} = a + y + cin.
module alu_arith_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       y_sel,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] y;

   always_comb begin
      y = '0;
      unique case (y_sel)
         ARITH_Y_ZERO: y = '0;
         ARITH_Y_B:    y = b;
         ARITH_Y_NB:   y = ~b;
         ARITH_Y_ONES: y = '1;
         default:      y = '0;
      endcase
   end

   // One extra bit so the carry out of the MSB is kept.
   assign {cout, sum} = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_32bit_modular.sv
// Registered 32-bit ALU: arithmetic, logic and single-bit shifts, one cycle of latency.
// Optional zero flag output Z when ALU_ZERO_FLAG_EN is defined.
module alu_32bit_modular
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             DinL,
   input  logic             DinR,
   input  logic [3:0]       sel,
`ifdef ALU_ZERO_FLAG_EN
   output logic             Z,
`endif
   output logic [WIDTH-1:0] F,
   output logic             Cout
);

   logic [WIDTH-1:0] arith_sum;
   logic             arith_cout;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH-1:0] f_d;
   logic             cout_d;

   alu_arith_unit #(
      .WIDTH (WIDTH)
   ) u_arith (
      .a     (A),
      .b     (B),
      .cin   (Cin),
      .y_sel (sel[1:0]),
      .sum   (arith_sum),
      .cout  (arith_cout)
   );

   always_comb begin
      logic_res = '0;
      unique case (sel[1:0])
         LOGIC_AND: logic_res = A & B;
         LOGIC_OR:  logic_res = A | B;
         LOGIC_XOR: logic_res = A ^ B;
         LOGIC_NOT: logic_res = ~A;
         default:   logic_res = '0;
      endcase
   end

   // Only the arithmetic group produces a carry.
   always_comb begin
      f_d    = '0;
      cout_d = 1'b0;
      unique case (sel[3:2])
         OP_ARITH: begin
            f_d    = arith_sum;
            cout_d = arith_cout;
         end
         OP_LOGIC: f_d = logic_res;
         OP_SHR:   f_d = {DinR, A[WIDTH-1:1]};
         OP_SHL:   f_d = {A[WIDTH-2:0], DinL};
         default:  f_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         F    <= '0;
         Cout <= 1'b0;
      end else begin
         F    <= f_d;
         Cout <= cout_d;
      end
   end

`ifdef ALU_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Z <= 1'b1;
      end else begin
         Z <= (f_d == '0);
      end
   end
`endif

endmodule

// File: tb/tb_alu_32bit_modular.sv
// Scoreboard bench for alu_32bit_modular: directed edge cases plus seeded random vectors.
module tb_alu_32bit_modular;

   typedef struct {
      logic [31:0] f;
      logic        cout;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic        Cin;
   logic        DinL;
   logic        DinR;
   logic [3:0]  sel;
   logic [31:0] F;
   logic        Cout;
`ifdef ALU_ZERO_FLAG_EN
   logic        Z;
`endif

   int checks = 0;
   int errors = 0;
   exp_t sb_q[$];

   alu_32bit_modular #(
      .WIDTH (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .DinL  (DinL),
      .DinR  (DinR),
      .sel   (sel),
`ifdef ALU_ZERO_FLAG_EN
      .Z     (Z),
`endif
      .F     (F),
      .Cout  (Cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference: 64-bit arithmetic, case on the full select code.
   function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic cin, input logic dl, input logic dr,
                                             input logic [3:0] s);
      longint unsigned ua, ub, r;
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = 0;
      case (s)
         4'h0: r = ua + cin;
         4'h1: r = ua + ub + cin;
         4'h2: r = ua + (ub ^ 64'hFFFF_FFFF) + cin;
         4'h3: r = ua + 64'hFFFF_FFFF + cin;
         4'h4: r = ua & ub;
         4'h5: r = ua | ub;
         4'h6: r = ua ^ ub;
         4'h7: r = ua ^ 64'hFFFF_FFFF;
         4'h8, 4'h9, 4'hA, 4'hB: r = (ua >> 1) | (dr ? 64'h8000_0000 : 64'd0);
         default: r = ((ua << 1) & 64'hFFFF_FFFF) | {63'd0, dl};
      endcase
      return r[32:0];
   endfunction

   task automatic check_val(input string name, input logic [31:0] f_act, input logic c_act,
                            input logic [31:0] f_exp, input logic c_exp);
      checks++;
      if (f_act !== f_exp || c_act !== c_exp) begin
         errors++;
         $display("FAIL %s: got F=%08h Cout=%0b, expected F=%08h Cout=%0b",
                  name, f_act, c_act, f_exp, c_exp);
      end
`ifdef ALU_ZERO_FLAG_EN
      checks++;
      if (Z !== (f_exp == 32'd0)) begin
         errors++;
         $display("FAIL %s Z: got %0b, expected %0b", name, Z, (f_exp == 32'd0));
      end
`endif
   endtask

   task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic dl, input logic dr, input logic [3:0] s,
                        input logic [31:0] f_exp, input logic c_exp);
      exp_t e;
      @(negedge clk);
      A = a; B = b; Cin = cin; DinL = dl; DinR = dr; sel = s;
      e.f = f_exp; e.cout = c_exp; e.name = name;
      sb_q.push_back(e);
   endtask

   // Monitor: the register loads every edge, so each pushed vector is due just after the next edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.name, F, Cout, e.f, e.cout);
         end
      end
   end

   initial begin
      logic [32:0] r;
      logic [31:0] ra, rb;
      logic        rc, rdl, rdr;
      logic [3:0]  rs;
      int          budget;

      rst_n = 1'b0; A = '0; B = '0; Cin = 0; DinL = 0; DinR = 0; sel = '0;
      #12;
      check_val("reset", F, Cout, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      apply("inc_wrap",  32'hFFFF_FFFF, 32'h0, 1, 0, 0, 4'h0, 32'h0000_0000, 1);
      apply("dec_zero",  32'h0000_0000, 32'h0, 0, 0, 0, 4'h3, 32'hFFFF_FFFF, 0);
      apply("dec_one",   32'h0000_0001, 32'h0, 0, 0, 0, 4'h3, 32'h0000_0000, 1);
      apply("xfer_ones", 32'h1234_5678, 32'h0, 1, 0, 0, 4'h3, 32'h1234_5678, 1);
      apply("xfer_a",    32'h8765_4321, 32'h0, 0, 0, 0, 4'h0, 32'h8765_4321, 0);
      apply("add_max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 4'h1, 32'hFFFF_FFFE, 1);
      apply("add_mid",   32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0, 4'h1, 32'hFFFF_FFFF, 0);
      apply("add_cin",   32'h1, 32'h1, 1, 0, 0, 4'h1, 32'h3, 0);
      apply("sub_4_3",   32'h4, 32'h3, 1, 0, 0, 4'h2, 32'h1, 1);
      apply("sub_4_3_1", 32'h4, 32'h3, 0, 0, 0, 4'h2, 32'h0, 1);
      apply("sub_3_4",   32'h3, 32'h4, 1, 0, 0, 4'h2, 32'hFFFF_FFFF, 0);
      apply("sub_3_4_1", 32'h3, 32'h4, 0, 0, 0, 4'h2, 32'hFFFF_FFFE, 0);
      apply("and",       32'h0F0F_0F0F, 32'hF0F0_F0F0, 1, 1, 1, 4'h4, 32'h0, 0);
      apply("or",        32'h0F0F_0F0F, 32'hF0F0_F0F0, 1, 1, 1, 4'h5, 32'hFFFF_FFFF, 0);
      apply("xor",       32'hAAAA_AAAA, 32'h5555_5555, 1, 0, 1, 4'h6, 32'hFFFF_FFFF, 0);
      apply("not",       32'h0000_0000, 32'h1234_5678, 1, 1, 0, 4'h7, 32'hFFFF_FFFF, 0);
      apply("shr_00",    32'h1234_5678, 32'h0, 1, 0, 0, 4'h8, 32'h091A_2B3C, 0);
      apply("shr_01",    32'h1234_5678, 32'h0, 1, 0, 1, 4'hB, 32'h891A_2B3C, 0);
      apply("shr_11",    32'h1234_5678, 32'h0, 0, 1, 1, 4'h8, 32'h891A_2B3C, 0);
      apply("shr_10",    32'h1234_5678, 32'h0, 0, 1, 0, 4'hB, 32'h091A_2B3C, 0);
      apply("shl_10",    32'h1234_5678, 32'h0, 1, 1, 0, 4'hC, 32'h2468_ACF1, 0);
      apply("shl_11",    32'h1234_5678, 32'h0, 1, 1, 1, 4'hD, 32'h2468_ACF1, 0);
      apply("shl_01",    32'h1234_5678, 32'h0, 0, 0, 1, 4'hC, 32'h2468_ACF0, 0);
      apply("shl_00",    32'h1234_5678, 32'h0, 0, 0, 0, 4'hD, 32'h2468_ACF0, 0);

      // Asynchronous reset mid-operation: drive a live vector, then drop rst_n between edges.
      @(negedge clk);
      A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Cin = 1; sel = 4'h1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_reset", F, Cout, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rdl = 1'($urandom);
         rdr = 1'($urandom); rs = 4'($urandom);
         if (i < 16) rs = 4'(i);
         r = ref_model(ra, rb, rc, rdl, rdr, rs);
         apply($sformatf("rand%0d_sel%0h", i, rs), ra, rb, rc, rdl, rdr, rs, r[31:0], r[32]);
      end

      budget = 10;
      while (sb_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected results never compared, required 0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
